// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//   DIV_COUNT_DEF / GAP_COUNT_DEF : default slot length and blanking gap
//   SEG_BLANK / AN_OFF            : all-off patterns (outputs are active-low)
//   scan_state_t                  : per-slot phase (blanking gap vs. digit shown)
package seg_display_pkg;

  localparam int         DIV_COUNT_DEF = 100000;
  localparam int         GAP_COUNT_DEF = 1000;
  localparam logic [6:0] SEG_BLANK     = 7'h7F;
  localparam logic [7:0] AN_OFF        = 8'hFF;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit value 0..F
//   seg    : segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Eight-digit multiplexed seven-segment display scanner.
// Each digit owns a slot of DIV_COUNT cycles; the first GAP_COUNT cycles of
// every slot are fully blanked so the previous digit's segments cannot ghost
// onto the next anode. Inputs are sampled once per frame (all eight slots) so
// a frame is always drawn from one consistent value.
//   clk, rst   : clock, synchronous active-high reset
//   data_in    : eight hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   blank_lz   : suppress leading zeros (digit 0 is always shown)
//   dp_mask    : bit i lights the decimal point of digit i
//   an         : digit anodes, active-low
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_done : one-cycle pulse at the start of every new frame
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int DIV_COUNT = DIV_COUNT_DEF,
  parameter int GAP_COUNT = GAP_COUNT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int             CNT_W    = $clog2(DIV_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_COUNT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       idx;
  scan_state_t      state;

  logic [31:0]      shadow_data;
  logic             shadow_blz;
  logic [7:0]       shadow_dp;

  logic             slot_last;
  logic             frame_last;
  logic [6:0]       seg_code_p0;
  logic             lz_blank_p0;

  assign slot_last  = (cnt == CNT_LAST);
  assign frame_last = slot_last && (idx == 3'd7);

  always_comb begin
    cnt_next = cnt + 1'b1;
    if (slot_last) begin
      cnt_next = '0;
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (shadow_data[{idx, 2'b00} +: 4]),
    .seg    (seg_code_p0)
  );

  // A digit is a leading zero when it and every higher nibble are zero.
  assign lz_blank_p0 = shadow_blz && (idx != 3'd0) &&
                       ((shadow_data >> {idx, 2'b00}) == 32'h0);

  // ---- stage p0 -> registered outputs ----
  // The state register tracks cnt_next so that state always matches the
  // current cnt; outputs are then registered from (cnt, idx, state).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 3'd0;
      state       <= ST_GAP;
      shadow_data <= 32'h0;
      shadow_blz  <= 1'b0;
      shadow_dp   <= 8'h00;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (slot_last) begin
        idx <= idx + 3'd1;
      end
      state <= (cnt_next < GAP_LIM) ? ST_GAP : ST_SHOW;

      if (frame_last) begin
        shadow_data <= data_in;
        shadow_blz  <= blank_lz;
        shadow_dp   <= dp_mask;
      end
      frame_done <= frame_last;

      if (state == ST_GAP) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(8'h01 << idx);
        seg <= lz_blank_p0 ? SEG_BLANK : seg_code_p0;
        dp  <= ~shadow_dp[idx];
      end
    end
  end

endmodule
